serial_header_framer: RTL

Parametrised serial header detector and payload framer. Watches a gated serial bit stream for any one of NUM_HDR programmable header patterns, using either a sliding-window or byte-aligned search. On a match it frames the following PAYLOAD_BYTES bytes into parallel words with RAM write strobes and addresses. It sits between the serial receive front end and the packet RAM, and replaces the single-byte, fixed-pattern header detector.

---
 rtl/serial_header_framer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_header_framer.sv
// Serial header detector and payload framer: hunts for one of NUM_HDR LSB-first
// header patterns, then packs the following PAYLOAD_BYTES bytes into RAM writes.
module serial_header_framer #(
  parameter int HDR_WIDTH = 8,
  parameter int NUM_HDR = 2,
  parameter logic [NUM_HDR*HDR_WIDTH-1:0] HDR_PATTERNS = {8'hC3, 8'hA5},
  parameter int ALIGNED = 0,
  parameter int PAYLOAD_BYTES = 4,
  parameter int TIMEOUT = 255,
  localparam int IW = (NUM_HDR > 1) ? $clog2(NUM_HDR) : 1,
  localparam int AW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1
) (
  input  logic          clk_50,
  input  logic          reset,
  input  logic          serial_data,
  input  logic          data_ena,
  output logic          header_found,
  output logic [IW-1:0] hdr_index,
  output logic [7:0]    byte_data,
  output logic          byte_valid,
  output logic [AW-1:0] byte_addr,
  output logic          pkt_done,
  output logic          pkt_abort
);

  // Bit counter is shared by header hunting and byte assembly
  localparam int CNT_MAX = (HDR_WIDTH > 8) ? HDR_WIDTH : 8;
  localparam int CW = $clog2(CNT_MAX + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] HDR_W_C   = CW'(HDR_WIDTH);
  localparam logic [CW-1:0] SEVEN_C   = CW'(7);
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
  localparam logic [AW-1:0] LAST_C    = AW'(PAYLOAD_BYTES - 1);
  localparam logic [AW-1:0] ADDR_ONE_C = AW'(1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [TW-1:0] IDLE_ONE_C = TW'(1);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t                 state_reg, state_next;
  logic [HDR_WIDTH-1:0]   win_reg, win_next;
  logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [AW-1:0]          byte_cnt_reg, byte_cnt_next;
  logic [TW-1:0]          idle_cnt_reg, idle_cnt_next;
  logic [7:0]             byte_sr_reg, byte_sr_next;
  logic                   header_found_reg, header_found_next;
  logic [IW-1:0]          hdr_index_reg, hdr_index_next;
  logic [7:0]             byte_data_reg, byte_data_next;
  logic                   byte_valid_reg, byte_valid_next;
  logic [AW-1:0]          byte_addr_reg, byte_addr_next;
  logic                   pkt_done_reg, pkt_done_next;
  logic                   pkt_abort_reg, pkt_abort_next;

  logic [HDR_WIDTH-1:0]   win_shift;
  logic [7:0]             byte_shift;
  logic [CW-1:0]          cnt_inc;
  logic [TW-1:0]          idle_inc;
  logic [NUM_HDR-1:0]     match_vec;
  logic                   match_any;
  logic [IW-1:0]          match_idx;
  logic                   cmp_en;

  assign win_shift  = {serial_data, win_reg[HDR_WIDTH-1:1]};
  assign byte_shift = {serial_data, byte_sr_reg[7:1]};
  assign cnt_inc    = bit_cnt_reg + CNT_ONE_C;
  assign idle_inc   = idle_cnt_reg + IDLE_ONE_C;

  // Compare against the window as it will look after this bit shifts in
  generate
    for (genvar gi = 0; gi < NUM_HDR; gi++) begin : g_match
      assign match_vec[gi] = (win_shift == HDR_PATTERNS[gi*HDR_WIDTH +: HDR_WIDTH]);
    end
  endgenerate

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    match_idx = '0;
    for (int i = NUM_HDR - 1; i >= 0; i--) begin
      if (match_vec[i]) match_idx = IW'(i);
    end
    match_any = |match_vec;
  end

  always_comb begin
    state_next        = state_reg;
    win_next          = win_reg;
    bit_cnt_next      = bit_cnt_reg;
    byte_cnt_next     = byte_cnt_reg;
    idle_cnt_next     = idle_cnt_reg;
    byte_sr_next      = byte_sr_reg;
    hdr_index_next    = hdr_index_reg;
    byte_data_next    = byte_data_reg;
    byte_addr_next    = byte_addr_reg;
    header_found_next = 1'b0;
    byte_valid_next   = 1'b0;
    pkt_done_next     = 1'b0;
    pkt_abort_next    = 1'b0;
    cmp_en            = 1'b0;

    case (state_reg)
      HUNT: begin
        if (data_ena) begin
          win_next = win_shift;
          if (ALIGNED != 0) begin
            if (cnt_inc == HDR_W_C) begin
              cmp_en       = 1'b1;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = cnt_inc;
            end
          end else begin
            if (cnt_inc >= HDR_W_C) begin
              cmp_en       = 1'b1;
              bit_cnt_next = HDR_W_C;
            end else begin
              bit_cnt_next = cnt_inc;
            end
          end
          if (cmp_en && match_any) begin
            header_found_next = 1'b1;
            hdr_index_next    = match_idx;
            state_next        = PAYLOAD;
            bit_cnt_next      = '0;
            byte_cnt_next     = '0;
            idle_cnt_next     = '0;
          end
        end
      end

      PAYLOAD: begin
        if (data_ena) begin
          idle_cnt_next = '0;
          byte_sr_next  = byte_shift;
          if (bit_cnt_reg == SEVEN_C) begin
            bit_cnt_next    = '0;
            byte_data_next  = byte_shift;
            byte_valid_next = 1'b1;
            byte_addr_next  = byte_cnt_reg;
            byte_cnt_next   = byte_cnt_reg + ADDR_ONE_C;
            if (byte_cnt_reg == LAST_C) begin
              pkt_done_next = 1'b1;
              state_next    = HUNT;
              win_next      = '0;
              byte_cnt_next = '0;
            end
          end else begin
            bit_cnt_next = cnt_inc;
          end
        end else if (idle_inc == TIMEOUT_C) begin
          // Partial byte in byte_sr_reg is simply discarded
          pkt_abort_next = 1'b1;
          state_next     = HUNT;
          win_next       = '0;
          bit_cnt_next   = '0;
          byte_cnt_next  = '0;
          idle_cnt_next  = '0;
        end else begin
          idle_cnt_next = idle_inc;
        end
      end

      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_reg        <= HUNT;
      win_reg          <= '0;
      bit_cnt_reg      <= '0;
      byte_cnt_reg     <= '0;
      idle_cnt_reg     <= '0;
      byte_sr_reg      <= '0;
      header_found_reg <= 1'b0;
      hdr_index_reg    <= '0;
      byte_data_reg    <= '0;
      byte_valid_reg   <= 1'b0;
      byte_addr_reg    <= '0;
      pkt_done_reg     <= 1'b0;
      pkt_abort_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      win_reg          <= win_next;
      bit_cnt_reg      <= bit_cnt_next;
      byte_cnt_reg     <= byte_cnt_next;
      idle_cnt_reg     <= idle_cnt_next;
      byte_sr_reg      <= byte_sr_next;
      header_found_reg <= header_found_next;
      hdr_index_reg    <= hdr_index_next;
      byte_data_reg    <= byte_data_next;
      byte_valid_reg   <= byte_valid_next;
      byte_addr_reg    <= byte_addr_next;
      pkt_done_reg     <= pkt_done_next;
      pkt_abort_reg    <= pkt_abort_next;
    end
  end

  assign header_found = header_found_reg;
  assign hdr_index    = hdr_index_reg;
  assign byte_data    = byte_data_reg;
  assign byte_valid   = byte_valid_reg;
  assign byte_addr    = byte_addr_reg;
  assign pkt_done     = pkt_done_reg;
  assign pkt_abort    = pkt_abort_reg;

endmodule
